seg_to_bin: RTL

- Monitor/decoder for the 4-digit multiplexed seven-segment display bus. It converts displayed segment patterns back into binary.
- Samples the active-low digit selects and active-low segment lines, and waits for each pattern to be stable.
- Decodes the stable pattern into a 4-bit nibble and holds one nibble per digit position.
- Used for score readback, self-check and bench observation of the display path without a camera or person watching the board.

---
 rtl/seg_to_bin.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/seg_to_bin.sv
// seg_to_bin: monitors a 4-digit multiplexed seven-segment bus and turns each
// stable, accepted segment pattern back into a per-digit binary nibble.
module seg_to_bin #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  an,
    input  logic [6:0]  num,
    input  logic        clr,
    output logic [15:0] value,
    output logic [3:0]  digit_vld,
    output logic        upd,
    output logic        bad_pat,
    output logic [7:0]  err_cnt
);

    localparam logic [7:0] CntMax = 8'(STABLE_CYCLES - 1);
    localparam logic [6:0] SegBlank = 7'h7F;

    typedef enum logic {StSettle, StLocked} state_e;

    // {an, num} as one sample word: an in [10:7], num in [6:0]
    logic [10:0] sync1_q, s2_q, s2d_q;
    logic [7:0]  cnt_q, cnt_d;
    state_e      state_q, state_d;
    logic        same;
    logic        accept;

    logic        glyph_ok;
    logic [3:0]  glyph_nib;
    logic        sel_ok;
    logic [1:0]  sel_idx;

    logic [15:0] value_q, value_d;
    logic [3:0]  vld_q, vld_d;
    logic        upd_q, upd_d;
    logic        bad_q, bad_d;
    logic [7:0]  err_q, err_d;

    assign same = (s2_q == s2d_q);

    // Two-flop synchronizer plus one delay stage used for change detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            s2_q    <= '0;
            s2d_q   <= '0;
        end else begin
            sync1_q <= {an, num};
            s2_q    <= sync1_q;
            s2d_q   <= s2_q;
        end
    end

    // Stability counter: restarts on any change, saturates at the accept threshold
    always_comb begin
        cnt_d = cnt_q;
        if (!same) begin
            cnt_d = '0;
        end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Settle/lock FSM: accept fires once per stable period
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            StSettle: begin
                if (same && (cnt_q == CntMax)) begin
                    accept  = 1'b1;
                    state_d = StLocked;
                end
            end
            StLocked: begin
                if (!same) begin
                    state_d = StSettle;
                end
            end
            default: state_d = StSettle;
        endcase
    end

    // Counter and FSM state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            state_q <= StSettle;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    // Glyph table: active-low segments a..g back to a hex nibble
    always_comb begin
        glyph_ok  = 1'b1;
        glyph_nib = 4'h0;
        case (s2_q[6:0])
            7'h01: glyph_nib = 4'h0;
            7'h4F: glyph_nib = 4'h1;
            7'h12: glyph_nib = 4'h2;
            7'h06: glyph_nib = 4'h3;
            7'h4C: glyph_nib = 4'h4;
            7'h24: glyph_nib = 4'h5;
            7'h20: glyph_nib = 4'h6;
            7'h0F: glyph_nib = 4'h7;
            7'h00: glyph_nib = 4'h8;
            7'h0C: glyph_nib = 4'h9;
            7'h08: glyph_nib = 4'hA;
            7'h60: glyph_nib = 4'hB;
            7'h31: glyph_nib = 4'hC;
            7'h42: glyph_nib = 4'hD;
            7'h30: glyph_nib = 4'hE;
            7'h38: glyph_nib = 4'hF;
            default: glyph_ok = 1'b0;
        endcase
    end

    // Digit select: only a single low anode identifies a digit slot
    always_comb begin
        sel_ok  = 1'b1;
        sel_idx = 2'd0;
        case (s2_q[10:7])
            4'b1110: sel_idx = 2'd0;
            4'b1101: sel_idx = 2'd1;
            4'b1011: sel_idx = 2'd2;
            4'b0111: sel_idx = 2'd3;
            default: sel_ok = 1'b0;
        endcase
    end

    // Output next-state: clear has priority and discards a coincident accept
    always_comb begin
        value_d = value_q;
        vld_d   = vld_q;
        upd_d   = 1'b0;
        bad_d   = 1'b0;
        err_d   = err_q;
        if (clr) begin
            value_d = '0;
            vld_d   = '0;
            upd_d   = (value_q != '0) || (vld_q != '0);
        end else if (accept && sel_ok) begin
            if (glyph_ok) begin
                value_d[{sel_idx, 2'b00} +: 4] = glyph_nib;
                vld_d[sel_idx]                 = 1'b1;
                upd_d = (value_q[{sel_idx, 2'b00} +: 4] != glyph_nib) || !vld_q[sel_idx];
            end else begin
                vld_d[sel_idx] = 1'b0;
                upd_d          = vld_q[sel_idx];
                if (s2_q[6:0] != SegBlank) begin
                    bad_d = 1'b1;
                    if (err_q != 8'hFF) begin
                        err_d = err_q + 8'd1;
                    end
                end
            end
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
            vld_q   <= '0;
            upd_q   <= 1'b0;
            bad_q   <= 1'b0;
            err_q   <= '0;
        end else begin
            value_q <= value_d;
            vld_q   <= vld_d;
            upd_q   <= upd_d;
            bad_q   <= bad_d;
            err_q   <= err_d;
        end
    end

    assign value     = value_q;
    assign digit_vld = vld_q;
    assign upd       = upd_q;
    assign bad_pat   = bad_q;
    assign err_cnt   = err_q;

endmodule
